// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-entry busy scoreboard and optional
// same-cycle write-to-read bypass. Entry 0 reads as zero and is never busy.
module regfile_mp #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned TAP_IDX = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [DATA_W-1:0]        tap_o
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] TapAddr = ADDR_W'(TAP_IDX);

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] mem_d [Depth];
    logic [Depth-1:0]  busy_q, busy_d;
    logic [Depth-1:0]  busy_set, busy_clr;
    logic              wr0_act, wr1_act, iss_act;

    // Gating with rst_n keeps writes/issues and their bypass out while in reset.
    assign wr0_act = wr0_en && (wr0_addr != '0) && rst_n;
    assign wr1_act = wr1_en && (wr1_addr != '0) && rst_n;
    assign iss_act = iss_en && (iss_addr != '0) && rst_n;

    always_comb begin
        mem_d = mem_q;
        if (wr0_act) mem_d[wr0_addr] = wr0_data;
        // wr1 is the younger retire slot, so it lands last.
        if (wr1_act) mem_d[wr1_addr] = wr1_data;
        mem_d[0] = '0;
    end

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (wr0_act) busy_clr[wr0_addr] = 1'b1;
        if (wr1_act) busy_clr[wr1_addr] = 1'b1;
        if (iss_act) busy_set[iss_addr] = 1'b1;
        // Set after clear: a new producer issued as the old one retires stays busy.
        busy_d    = (busy_q & ~busy_clr) | busy_set;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign idx = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem_q[idx];
            busy = busy_q[idx];
            if (BYPASS != 0) begin
                if (wr0_act && (wr0_addr == idx)) data = wr0_data;
                if (wr1_act && (wr1_addr == idx)) data = wr1_data;
                if (busy_clr[idx]) busy = 1'b0;
            end
            if (!rst_n || (idx == '0)) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]                  = busy;
    end

    assign tap_o = mem_q[TapAddr];

endmodule
